bp_be_wb_arbiter: RTL and testbench

BP_BE_WB_ARBITER -- requirements
Module: bp_be_wb_arbiter

---
 rtl/bp_be_pkg.sv | 40 ++++
 rtl/bp_be_wb_rr_arb.sv | 50 +++++
 rtl/bp_be_wb_arbiter.sv | 102 ++++++++++
 tb/tb_bp_be_wb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Backend shared types: the writeback packet, writeback source tags
// and helpers used by the writeback arbiter.
package bp_be_pkg;

  localparam int dword_width_gp    = 64;
  localparam int reg_addr_width_gp = 5;

  typedef struct packed {
    logic                         rd_w_v;
    logic                         fp_not_int;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    rd_data;
  } bp_be_wb_pkt_s;

  typedef enum logic [3:0] {
    e_wb_src_pipe = 4'd0,
    e_wb_src_ll0  = 4'd1,
    e_wb_src_ll1  = 4'd2,
    e_wb_src_ll2  = 4'd3,
    e_wb_src_ll3  = 4'd4,
    e_wb_src_ll4  = 4'd5,
    e_wb_src_ll5  = 4'd6,
    e_wb_src_ll6  = 4'd7,
    e_wb_src_ll7  = 4'd8
  } bp_be_wb_src_e;

  function automatic bp_be_wb_src_e ll_src(input logic [2:0] idx);
    return bp_be_wb_src_e'({1'b0, idx} + 4'd1);
  endfunction

  // x0 is hardwired zero; f0 is a real register
  function automatic logic wb_rd_w_v(
    input logic                         v,
    input logic                         fp_not_int,
    input logic [reg_addr_width_gp-1:0] rd_addr
  );
    return v & (fp_not_int | (|rd_addr));
  endfunction

endpackage

// File: rtl/bp_be_wb_rr_arb.sv
// Round-robin grant among long-latency writeback requesters.
// ptr_q holds the index searched first on the next grant.
module bp_be_wb_rr_arb #(
  parameter  int num_ll_p = 3,
  localparam int idx_w    = $clog2(num_ll_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                en_i,
  input  logic [num_ll_p-1:0] v_i,
  output logic [num_ll_p-1:0] grant_o,
  output logic                grant_v_o,
  output logic [idx_w-1:0]    grant_idx_o
);

  logic [idx_w-1:0] ptr_q, ptr_d;
  int               j;

  always_comb begin
    grant_v_o   = 1'b0;
    grant_idx_o = '0;
    j           = 0;
    for (int i = 0; i < num_ll_p; i++) begin
      j = int'(ptr_q) + i;
      if (j >= num_ll_p) j = j - num_ll_p;
      if (en_i && !grant_v_o && v_i[j]) begin
        grant_v_o   = 1'b1;
        grant_idx_o = idx_w'(j);
      end
    end
  end

  assign grant_o = grant_v_o
    ? ({{(num_ll_p-1){1'b0}}, 1'b1} << grant_idx_o)
    : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_v_o) begin
      if (grant_idx_o == idx_w'(num_ll_p-1)) ptr_d = '0;
      else                                   ptr_d = grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_be_wb_arbiter.sv
// Writeback arbiter: pipeline first, long-latency units round-robin.
// BP_BE_WB_ARB_STARVE_EN adds the starvation counter and pipe stall.
module bp_be_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_ll_p         = 3,
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int starve_limit_p   = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 pipe_v_i,
  input  logic                                 pipe_fp_not_int_i,
  input  logic [reg_addr_width_p-1:0]          pipe_rd_addr_i,
  input  logic [dword_width_p-1:0]             pipe_rd_data_i,
  input  logic [num_ll_p-1:0]                  ll_v_i,
  input  logic [num_ll_p-1:0]                  ll_fp_not_int_i,
  input  logic [num_ll_p*reg_addr_width_p-1:0] ll_rd_addr_i,
  input  logic [num_ll_p*dword_width_p-1:0]    ll_rd_data_i,
  output logic [num_ll_p-1:0]                  ll_yumi_o,
  output logic                                 pipe_stall_o,
  output bp_be_wb_pkt_s                        wb_pkt_o
);

  localparam int idx_w = $clog2(num_ll_p);

  logic             gnt_v;
  logic [idx_w-1:0] gnt_idx;
  logic             sel_v;
  bp_be_wb_src_e    src;
  bp_be_wb_pkt_s    pkt_d, pkt_q;

  // Reset gates the enable so no grant escapes while held in reset
  bp_be_wb_rr_arb #(
    .num_ll_p(num_ll_p)
  ) rr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (~pipe_v_i & reset_n_i),
    .v_i        (ll_v_i),
    .grant_o    (ll_yumi_o),
    .grant_v_o  (gnt_v),
    .grant_idx_o(gnt_idx)
  );

  always_comb begin
    sel_v = pipe_v_i | gnt_v;
    src   = pipe_v_i ? e_wb_src_pipe : ll_src(3'(gnt_idx));
    pkt_d = '0;
    if (sel_v) begin
      if (src == e_wb_src_pipe) begin
        pkt_d.fp_not_int = pipe_fp_not_int_i;
        pkt_d.rd_addr    = pipe_rd_addr_i;
        pkt_d.rd_data    = pipe_rd_data_i;
      end else begin
        pkt_d.fp_not_int = ll_fp_not_int_i[gnt_idx];
        pkt_d.rd_addr    =
          ll_rd_addr_i[gnt_idx*reg_addr_width_p +: reg_addr_width_p];
        pkt_d.rd_data    =
          ll_rd_data_i[gnt_idx*dword_width_p +: dword_width_p];
      end
      pkt_d.rd_w_v = wb_rd_w_v(1'b1, pkt_d.fp_not_int, pkt_d.rd_addr);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pkt_q <= '0;
    else            pkt_q <= pkt_d;
  end

  assign wb_pkt_o = pkt_q;

`ifdef BP_BE_WB_ARB_STARVE_EN
  localparam int cnt_w = $clog2(starve_limit_p+1);

  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             stall_q;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_v || !(|ll_v_i))                  cnt_d = '0;
    else if (cnt_q != cnt_w'(starve_limit_p)) cnt_d = cnt_q + 1'b1;
  end

  // Stall tracks the saturated counter, so a grant drops it next edge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= (cnt_d == cnt_w'(starve_limit_p));
    end
  end

  assign pipe_stall_o = stall_q;
`else
  assign pipe_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// Directed bench for bp_be_wb_arbiter with an expected-packet queue.
// Stall expectations follow BP_BE_WB_ARB_STARVE_EN.
module tb_bp_be_wb_arbiter;
  import bp_be_pkg::*;

`ifdef BP_BE_WB_ARB_STARVE_EN
  localparam logic STARVE = 1'b1;
`else
  localparam logic STARVE = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          pipe_v;
  logic          pipe_fp;
  logic [4:0]    pipe_rd;
  logic [63:0]   pipe_data;
  logic [2:0]    ll_v;
  logic [2:0]    ll_fp;
  logic [14:0]   ll_addr;
  logic [191:0]  ll_data;
  logic [2:0]    yumi;
  logic          stall;
  bp_be_wb_pkt_s pkt;

  int n_cmp = 0;
  int n_err = 0;
  bp_be_wb_pkt_s sb[$];

  bp_be_wb_arbiter #(
    .num_ll_p(3),
    .dword_width_p(64),
    .reg_addr_width_p(5),
    .starve_limit_p(8)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .pipe_v_i         (pipe_v),
    .pipe_fp_not_int_i(pipe_fp),
    .pipe_rd_addr_i   (pipe_rd),
    .pipe_rd_data_i   (pipe_data),
    .ll_v_i           (ll_v),
    .ll_fp_not_int_i  (ll_fp),
    .ll_rd_addr_i     (ll_addr),
    .ll_rd_data_i     (ll_data),
    .ll_yumi_o        (yumi),
    .pipe_stall_o     (stall),
    .wb_pkt_o         (pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bp_be_wb_pkt_s model(input logic pv,
                                          input logic [2:0] gy);
    bp_be_wb_pkt_s m;
    m = '0;
    if (pv) begin
      m.fp_not_int = pipe_fp;
      m.rd_addr    = pipe_rd;
      m.rd_data    = pipe_data;
    end else begin
      for (int i = 0; i < 3; i++)
        if (gy[i]) begin
          m.fp_not_int = ll_fp[i];
          m.rd_addr    = ll_addr[i*5 +: 5];
          m.rd_data    = ll_data[i*64 +: 64];
        end
    end
    m.rd_w_v = (pv || (gy != 3'b000)) &&
               (m.fp_not_int || (m.rd_addr != 5'd0));
    return m;
  endfunction

  task automatic pop_chk(input string tag);
    bp_be_wb_pkt_s e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s obs=empty_queue exp=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, 128'(pkt), 128'(e));
    end
  endtask

  task automatic step(input logic pv, input logic pfp,
                      input logic [4:0] prd, input logic [63:0] pd,
                      input logic [2:0] lv, input logic [2:0] exp_y,
                      input logic exp_st, input string tag);
    @(negedge clk);
    pipe_v    = pv;
    pipe_fp   = pfp;
    pipe_rd   = prd;
    pipe_data = pd;
    ll_v      = lv;
    #1;
    chk({tag, "_yumi"}, 128'(yumi), 128'(exp_y));
    chk({tag, "_stall"}, 128'(stall), 128'(exp_st & STARVE));
    sb.push_back(model(pv, exp_y));
    @(posedge clk);
    #1;
    pop_chk({tag, "_pkt"});
  endtask

  initial begin
    reset_n   = 1'b0;
    pipe_v    = 1'b0;
    pipe_fp   = 1'b0;
    pipe_rd   = '0;
    pipe_data = '0;
    ll_v      = 3'b111;
    ll_fp     = 3'b010;
    ll_addr   = {5'd3, 5'd2, 5'd1};
    ll_data   = {64'h300, 64'h200, 64'h100};
    #2;
    chk("rst_pkt", 128'(pkt), 128'(0));
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_yumi", 128'(yumi), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(1, 0, 5, 64'hAA, 3'b111, 3'b000, 0, "pipe_prio");
    step(0, 0, 0, 0, 3'b111, 3'b001, 0, "rr0");
    step(0, 0, 0, 0, 3'b111, 3'b010, 0, "rr1");
    step(0, 0, 0, 0, 3'b111, 3'b100, 0, "rr2");
    step(0, 0, 0, 0, 3'b111, 3'b001, 0, "rr3");
    step(0, 0, 0, 0, 3'b000, 3'b000, 0, "idle");

    ll_fp[1]       = 1'b0;
    ll_addr[5 +: 5] = 5'd0;
    step(0, 0, 0, 0, 3'b010, 3'b010, 0, "x0_drop");
    ll_fp[2]        = 1'b1;
    ll_addr[10 +: 5] = 5'd0;
    step(0, 0, 0, 0, 3'b100, 3'b100, 0, "f0_write");
    step(1, 0, 0, 64'h55, 3'b000, 3'b000, 0, "pipe_x0");

    ll_fp   = 3'b010;
    ll_addr = {5'd3, 5'd2, 5'd1};
    step(0, 0, 0, 0, 3'b101, 3'b001, 0, "skip0");
    step(0, 0, 0, 0, 3'b101, 3'b100, 0, "skip1");

    for (int k = 1; k <= 8; k++)
      step(1, 0, 7, 64'(k), 3'b001, 3'b000, 0, "starve");
    step(1, 0, 7, 64'h9, 3'b001, 3'b000, 1, "stall_pipe");
    step(0, 0, 0, 0, 3'b001, 3'b001, 1, "stall_grant");
    step(0, 0, 0, 0, 3'b000, 3'b000, 0, "stall_clear");

    for (int k = 1; k <= 8; k++)
      step(1, 1, 9, 64'(k + 16), 3'b010, 3'b000, 0, "starve2");

    @(negedge clk);
    pipe_v = 1'b0;
    ll_v   = 3'b011;
    #1;
    chk("pend_yumi", 128'(yumi), 128'(3'b010));
    chk("pend_stall", 128'(stall), 128'(STARVE));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_pkt", 128'(pkt), 128'(0));
    chk("arst_stall", 128'(stall), 128'(0));
    chk("arst_yumi", 128'(yumi), 128'(0));
    @(posedge clk);
    #1;
    chk("arst_hold_pkt", 128'(pkt), 128'(0));
    reset_n = 1'b1;
    step(0, 0, 0, 0, 3'b011, 3'b001, 0, "post_rst");
    step(0, 0, 0, 0, 3'b011, 3'b010, 0, "post_rst2");

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
